// File: rtl/count_readout_tx_pkg.sv
// -----------------------------------------------------------------------------
// count_readout_tx_pkg
// Shared definitions for the count readout return path:
//   - WORD_W          : width of one link word (16)
//   - HDR_TAG_DEFAULT : default upper byte of the header word (8'hA5)
//   - state_t         : framer FSM state encoding
// -----------------------------------------------------------------------------
package count_readout_tx_pkg;

  localparam int         WORD_W          = 16;
  localparam logic [7:0] HDR_TAG_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

endpackage

// File: rtl/count_readout_tx_snapshot.sv
// -----------------------------------------------------------------------------
// count_snapshot
// Holds the most recent photon-count snapshot until the framer consumes it,
// and flags (sticky) when an unread snapshot gets overwritten.
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   i_count_value : counter value, captured when i_count_done=1
//   i_count_done  : one-cycle capture pulse
//   i_consume     : framer takes the current snapshot on this edge
//   i_clr_ovr     : one-cycle clear of the overrun flag
//   o_snap        : snapshot value
//   o_snap_valid  : snapshot present and not yet consumed
//   o_overrun     : sticky overwrite flag
// -----------------------------------------------------------------------------
module count_snapshot #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CNT_W-1:0] i_count_value,
  input  logic             i_count_done,
  input  logic             i_consume,
  input  logic             i_clr_ovr,
  output logic [CNT_W-1:0] o_snap,
  output logic             o_snap_valid,
  output logic             o_overrun
);

  logic [CNT_W-1:0] r_snap;
  logic             r_snap_valid;
  logic             r_overrun;
  logic             w_ovr_set;

  // Overwriting a snapshot that is being consumed on the same edge loses
  // nothing, so only an unconsumed overwrite counts as an overrun.
  assign w_ovr_set = i_count_done & r_snap_valid & ~i_consume;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_snap       <= '0;
      r_snap_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (i_count_done) begin
        r_snap       <= i_count_value;
        r_snap_valid <= 1'b1;
      end else if (i_consume) begin
        r_snap_valid <= 1'b0;
      end

      // Set has priority over clear.
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (i_clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_snap       = r_snap;
  assign o_snap_valid = r_snap_valid;
  assign o_overrun    = r_overrun;

endmodule

// File: rtl/count_readout_tx.sv
// -----------------------------------------------------------------------------
// count_readout_tx
// Frames the photon-count result and streams it to the SPI slave transmitter
// as 16-bit words: header {HDR_TAG, SEQ}, CNT_W/16 count words (MS first),
// then the XOR checksum of all preceding words.
// Ports:
//   CLK, RST     : clock, synchronous active-high reset
//   COUNT_VALUE  : photon count, sampled while COUNT_DONE=1
//   COUNT_DONE   : one-cycle pulse, counting window finished
//   READ_DATA    : controller level; rising edge requests one frame
//   CLR_OVR      : one-cycle pulse, clears OVERRUN
//   TX_READY     : transmitter accepts a word
//   TX_WORD      : word offered
//   TX_VALID     : TX_WORD valid
//   BUSY         : frame in flight
//   OVERRUN      : sticky, an unread snapshot was overwritten
//   SEQ          : completed frames modulo 256
// -----------------------------------------------------------------------------
module count_readout_tx
  import count_readout_tx_pkg::*;
#(
  parameter int         CNT_W   = 32,
  parameter logic [7:0] HDR_TAG = HDR_TAG_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CNT_W-1:0] COUNT_VALUE,
  input  logic             COUNT_DONE,
  input  logic             READ_DATA,
  input  logic             CLR_OVR,
  input  logic             TX_READY,
  output logic [15:0]      TX_WORD,
  output logic             TX_VALID,
  output logic             BUSY,
  output logic             OVERRUN,
  output logic [7:0]       SEQ
);

  // Index of the last count word; CNT_W is at most 64, so 3 bits suffice.
  localparam logic [2:0] N_IDX = 3'(CNT_W / WORD_W);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_rd_prev;
  logic               r_req_pend;
  logic [CNT_W-1:0]   r_shift;
  logic [2:0]         r_idx;
  logic [WORD_W-1:0]  r_csum;
  logic [WORD_W-1:0]  r_word;
  logic               r_valid;
  logic [7:0]         r_seq;

  logic [CNT_W-1:0]   w_snap;
  logic               w_snap_valid;
  logic               w_overrun;
  logic               w_xfer;
  logic               w_launch;
  logic               w_rise;
  logic               w_last_data;
  logic [WORD_W-1:0]  w_hdr_word;
  logic [WORD_W-1:0]  w_next_data;

  assign w_xfer      = r_valid & TX_READY;
  assign w_launch    = (r_state == ST_IDLE) & r_req_pend & w_snap_valid;
  // Edge detect compares the live input with last cycle's sample, so the
  // request is pending one edge after the rise and launches on the next.
  assign w_rise      = READ_DATA & ~r_rd_prev;
  assign w_last_data = (r_idx == N_IDX);
  assign w_hdr_word  = {HDR_TAG, r_seq};
  assign w_next_data = r_shift[CNT_W-1 -: WORD_W];

  count_snapshot #(
    .CNT_W (CNT_W)
  ) u_snapshot (
    .CLK           (CLK),
    .RST           (RST),
    .i_count_value (COUNT_VALUE),
    .i_count_done  (COUNT_DONE),
    .i_consume     (w_launch),
    .i_clr_ovr     (CLR_OVR),
    .o_snap        (w_snap),
    .o_snap_valid  (w_snap_valid),
    .o_overrun     (w_overrun)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_launch)                  w_state_next = ST_HDR;
      ST_HDR:  if (w_xfer)                    w_state_next = ST_DATA;
      ST_DATA: if (w_xfer && w_last_data)     w_state_next = ST_CSUM;
      ST_CSUM: if (w_xfer)                    w_state_next = ST_IDLE;
      default:                                w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_rd_prev  <= 1'b0;
      r_req_pend <= 1'b0;
      r_shift    <= '0;
      r_idx      <= '0;
      r_csum     <= '0;
      r_word     <= '0;
      r_valid    <= 1'b0;
      r_seq      <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rd_prev <= READ_DATA;

      // Edges while a request is pending or a frame is running are dropped.
      if (w_launch) begin
        r_req_pend <= 1'b0;
      end else if (w_rise && !r_req_pend && r_state == ST_IDLE) begin
        r_req_pend <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_shift <= w_snap;
            r_word  <= w_hdr_word;
            r_csum  <= w_hdr_word;
            r_valid <= 1'b1;
          end
        end
        ST_HDR: begin
          if (w_xfer) begin
            r_word  <= w_next_data;
            r_csum  <= r_csum ^ w_next_data;
            r_shift <= r_shift << WORD_W;
            r_idx   <= 3'd1;
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            if (w_last_data) begin
              // Accumulator already holds header ^ every count word.
              r_word <= r_csum;
            end else begin
              r_word  <= w_next_data;
              r_csum  <= r_csum ^ w_next_data;
              r_shift <= r_shift << WORD_W;
              r_idx   <= r_idx + 3'd1;
            end
          end
        end
        ST_CSUM: begin
          if (w_xfer) begin
            r_word  <= '0;
            r_valid <= 1'b0;
            r_seq   <= r_seq + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign TX_WORD  = r_word;
  assign TX_VALID = r_valid;
  assign BUSY     = (r_state != ST_IDLE);
  assign OVERRUN  = w_overrun;
  assign SEQ      = r_seq;

endmodule

// File: tb/tb_count_readout_tx.sv
// -----------------------------------------------------------------------------
// tb_count_readout_tx
// Directed sequence with randomized count values and TX_READY patterns.
// Expected frames come from a small model: header {A5, seq}, the count split
// into upper/lower 16-bit halves, and the XOR of those three words.
// -----------------------------------------------------------------------------
module tb_count_readout_tx;

  localparam int CNT_W = 32;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [CNT_W-1:0]  COUNT_VALUE = '0;
  logic              COUNT_DONE = 1'b0;
  logic              READ_DATA = 1'b0;
  logic              CLR_OVR = 1'b0;
  logic              TX_READY = 1'b0;
  logic [15:0]       TX_WORD;
  logic              TX_VALID;
  logic              BUSY;
  logic              OVERRUN;
  logic [7:0]        SEQ;

  count_readout_tx #(.CNT_W(CNT_W), .HDR_TAG(8'hA5)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .COUNT_VALUE (COUNT_VALUE),
    .COUNT_DONE  (COUNT_DONE),
    .READ_DATA   (READ_DATA),
    .CLR_OVR     (CLR_OVR),
    .TX_READY    (TX_READY),
    .TX_WORD     (TX_WORD),
    .TX_VALID    (TX_VALID),
    .BUSY        (BUSY),
    .OVERRUN     (OVERRUN),
    .SEQ         (SEQ)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_seq = 0;
  logic [31:0] m_snap = '0;
  bit          m_snap_valid = 0;
  bit          m_overrun = 0;
  logic [15:0] exp_w [0:3];
  int          busy_cycles;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_done(input logic [31:0] v);
    COUNT_VALUE = v;
    COUNT_DONE  = 1'b1;
    tick();
    COUNT_DONE  = 1'b0;
    if (m_snap_valid) m_overrun = 1;
    m_snap       = v;
    m_snap_valid = 1;
  endtask

  task automatic build_frame(input int seq, input logic [31:0] v);
    exp_w[0] = {8'hA5, 8'(seq)};
    exp_w[1] = 16'(v >> 16);
    exp_w[2] = 16'(v & 32'h0000_FFFF);
    exp_w[3] = exp_w[0] ^ exp_w[1] ^ exp_w[2];
  endtask

  // Raise READ_DATA with a snapshot present: valid must appear on the 2nd edge.
  task automatic start_read();
    READ_DATA = 1'b1;
    tick();
    chk("pre_launch_valid", TX_VALID, 0);
    tick();
    chk("launch_valid", TX_VALID, 1);
    chk("launch_busy", BUSY, 1);
  endtask

  // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: random.
  // stop_after>0 returns right after that many words have transferred.
  task automatic collect(input int mode, input logic [31:0] v, input int stop_after);
    int          n = 0;
    bit          stalled = 0;
    logic [15:0] held = '0;
    int          lim;
    build_frame(m_seq, v);
    busy_cycles = 0;
    lim = (stop_after > 0) ? stop_after : 4;
    READ_DATA = 1'b0;
    for (int c = 0; c < 200 && n < lim; c++) begin
      case (mode)
        0:       TX_READY = 1'b1;
        1:       TX_READY = ((c % 3) == 0);
        default: TX_READY = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        chk("stall_valid", TX_VALID, 1);
        chk("stall_word", TX_WORD, held);
      end
      if (BUSY) busy_cycles++;
      if (TX_VALID && TX_READY) begin
        chk($sformatf("word%0d seq=%0d", n, m_seq), TX_WORD, exp_w[n]);
        n++;
        stalled = 0;
      end else begin
        stalled = TX_VALID;
        held    = TX_WORD;
      end
      tick();
    end
    TX_READY = 1'b0;
    chk("nwords", n, lim);
    if (stop_after == 0) begin
      m_seq = (m_seq + 1) % 256;
      chk("end_valid", TX_VALID, 0);
      chk("end_busy", BUSY, 0);
      chk("seq", SEQ, m_seq);
      chk("overrun", OVERRUN, m_overrun);
    end
  endtask

  task automatic model_reset();
    m_seq = 0;
    m_snap_valid = 0;
    m_overrun = 0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] v2;

    // Reset state
    RST = 1'b1;
    tick();
    tick();
    chk("rst_word", TX_WORD, 0);
    chk("rst_valid", TX_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_seq", SEQ, 0);
    RST = 1'b0;
    model_reset();
    tick();

    // 1: known value, ready held high, 4 busy cycles
    pulse_done(32'h1234_5678);
    chk("c1_overrun", OVERRUN, 0);
    v = m_snap; m_snap_valid = 0;
    start_read();
    collect(0, v, 0);
    chk("c1_busy_cycles", busy_cycles, 4);

    // 2: same value, ready pattern 1,0,0
    pulse_done(32'h1234_5678);
    v = m_snap; m_snap_valid = 0;
    start_read();
    collect(1, v, 0);

    // 3: request before snapshot waits
    READ_DATA = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("c3_wait_valid", TX_VALID, 0);
    end
    chk("c3_wait_busy", BUSY, 0);
    pulse_done(32'd7);
    chk("c3_snap_edge_valid", TX_VALID, 0);
    v = m_snap; m_snap_valid = 0;
    tick();
    chk("c3_launch_valid", TX_VALID, 1);
    collect(2, v, 0);

    // 4: overrun, newest wins, clear
    pulse_done(32'd5);
    pulse_done(32'd9);
    chk("c4_overrun_set", OVERRUN, m_overrun);
    v = m_snap; m_snap_valid = 0;
    start_read();
    collect(2, v, 0);
    CLR_OVR = 1'b1;
    tick();
    CLR_OVR = 1'b0;
    m_overrun = 0;
    chk("c4_overrun_clr", OVERRUN, m_overrun);
    // set and clear together: set wins
    pulse_done($urandom);
    CLR_OVR = 1'b1;
    pulse_done($urandom);
    CLR_OVR = 1'b0;
    chk("c4_set_beats_clr", OVERRUN, m_overrun);

    // 5: reset mid-frame after two words
    v = m_snap; m_snap_valid = 0;
    start_read();
    collect(2, v, 2);
    RST = 1'b1;
    tick();
    chk("c5_valid", TX_VALID, 0);
    chk("c5_busy", BUSY, 0);
    chk("c5_seq", SEQ, 0);
    chk("c5_overrun", OVERRUN, 0);
    RST = 1'b0;
    model_reset();
    tick();
    pulse_done($urandom);
    v = m_snap; m_snap_valid = 0;
    start_read();
    collect(0, v, 0);

    // 6: 256 frames wrap SEQ; COUNT_DONE on launch edge is kept
    RST = 1'b1;
    tick();
    RST = 1'b0;
    model_reset();
    tick();
    for (int f = 0; f < 256; f++) begin
      pulse_done($urandom);
      v = m_snap; m_snap_valid = 0;
      start_read();
      collect(2, v, 0);
    end
    chk("c6_seq_wrap", SEQ, m_seq);
    pulse_done($urandom);
    v  = m_snap;
    v2 = $urandom;
    READ_DATA = 1'b1;
    tick();
    chk("c6_pre_launch_valid", TX_VALID, 0);
    COUNT_VALUE = v2;
    COUNT_DONE  = 1'b1;
    tick();
    COUNT_DONE  = 1'b0;
    m_snap = v2;
    m_snap_valid = 1;
    chk("c6_launch_valid", TX_VALID, 1);
    collect(0, v, 0);
    v = m_snap; m_snap_valid = 0;
    start_read();
    collect(2, v, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
